calc_ctrl: RTL and testbench
============================

# calc_ctrl

Registered, parametrised control core for the binary calculator. It debounces the push-button code, decodes a command once per press-and-release, and loads the operand and opcode registers from the switches. It sequences an execute with a programmable ALU wait, latches the result and an encoded flag digit, and drives the display value. It sits between the board I/O (switches, buttons) and the existing ALU and seven-segment display driver, and replaces the previous combinational decode/mux glue.

## Interface
- `W`, 12: operand, result and switch width.
- `DB_CYCLES`, 16: consecutive identical synchronised samples required to accept a button code (≥2).
- `ALU_LAT`, 1: cycles between operand stability and result capture (≥1).
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `switch` input W: operand/opcode data, static while a command commits.
- `bt` input 4: raw button code, asynchronous.
- `alu_result` input W: ALU output.
- `alu_err`, `alu_zero`, `alu_ovf` input 1 each: ALU flags.
- `r0_o`, `r1_o` output W: operand registers to the ALU.
- `rs_o` output 4: opcode register to the ALU (`switch[3:0]`).
- `disp_val` output W: value to display digits 0–2.
- `disp_flag` output 4: flag digit (digit 3).
- `busy` output 1: execute in progress.

## Operation
- Input path: `bt` is synchronised through 2 flops, then debounced by `calc_debounce`. The stable code is accepted after `DB_CYCLES` equal samples.
- FSM states:
  - IDLE: on a nonzero stable code → ARMED, with `acc <= code`.
  - ARMED: `acc <= acc | code` while the code is nonzero. When the stable code reaches 0, commit `acc` (one cycle), then → IDLE.
  - WAIT: counts `ALU_LAT` cycles with `busy=1`, then captures and → IDLE.
- Committed command (OR of all codes seen in the press):
  - 1: view r0. 2: view r1. 4: view rs.
  - 8: execute and view result.
  - 9: r0 <= switch. 10: r1 <= switch. 12: rs <= switch[3:0].
  - Any other value: ignored, no state change.
- Loads do not change the view.
- Execute: IDLE→WAIT. At capture, `res <= alu_result` and `flag` is encoded with priority err=10, zero=2, ovf=8, else 0.
- `disp_val` is selected by the view register: result/r0/r1/{0,rs}. `disp_flag` = `flag` when the view is result, else 0.
- While in WAIT, button presses still debounce, but a commit arriving in WAIT is dropped (no queueing).
- Reset mid-press or mid-WAIT: everything is cleared immediately and no partial command is applied.

## Timing
- Reset values: `r0_o=0`, `r1_o=0`, `rs_o=0`, res=0, `flag=0`, view=result, `disp_val=0`, `disp_flag=0`, `busy=0`, FSM=IDLE, acc=0.
- Raw release to register update: 2 (sync) + `DB_CYCLES` + 1 clocks. `switch` is sampled on the commit edge.
- Execute commit to capture: `busy` rises the clock after commit and stays high for exactly `ALU_LAT` cycles. `res`/`flag` update on the edge where `busy` falls.
- A glitch shorter than `DB_CYCLES` samples never changes the stable code.

## Configuration
- Macro: `CALC_ACC_EN`.
- Defined: accumulator mode. At execute capture with `alu_err=0`, r0 <= alu_result in the same edge as res. With `alu_err=1`, r0 is unchanged.
- Undefined: r0 is written only by command 9.

## Structure
- `calc_pkg`:
  - command codes (CMD_VIEW_R0=1, CMD_VIEW_R1=2, CMD_VIEW_RS=4, CMD_EXEC=8, CMD_LD_R0=9, CMD_LD_R1=10, CMD_LD_RS=12);
  - flag digit constants (FLG_ERR=10, FLG_ZERO=2, FLG_OVF=8, FLG_NONE=0);
  - FSM state enum (IDLE, ARMED, WAIT);
  - view enum.
- Sub-module `calc_debounce`: 2-flop synchroniser plus stability counter. Parameter `DB_CYCLES`; outputs the stable 4-bit code.

## Test plan
Bench parameters: `DB_CYCLES=4`, `ALU_LAT=2`.
- Reset: assert `rst_n=0` mid-WAIT → all outputs 0, `busy=0` immediately; after release, commands work normally.
- Load: `switch=201`, `bt` 1→9 held 10 cycles then 0 → `r0_o=201` exactly 7 clocks after release (not r0 view); `bt=10` with `switch=40` → `r1_o=40`.
- Glitch: `bt=8` for 3 cycles only → no commit, `busy` stays 0.
- Execute: r0=201, r1=40, rs=0, ALU model add with 2-cycle delay; `bt=8` press/release → `busy` high 2 cycles, `disp_val=241`, `disp_flag=0`. Repeat with ALU zero → `disp_flag=2`; with err+zero → `disp_flag=10`.
- View and drop: `bt=2` → `disp_val=40`, `disp_flag=0`. Commit `bt=9` during WAIT → r0 unchanged.
- `CALC_ACC_EN`: 201+40 execute → `r0_o=241`. Second execute → `r0_o=281`. Err case leaves r0 unchanged.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator control core:
// command codes, flag digits, FSM and view encodings.
package calc_pkg;

    localparam int CODE_W = 4;

    localparam logic [3:0] CMD_VIEW_R0 = 4'd1;
    localparam logic [3:0] CMD_VIEW_R1 = 4'd2;
    localparam logic [3:0] CMD_VIEW_RS = 4'd4;
    localparam logic [3:0] CMD_EXEC    = 4'd8;
    localparam logic [3:0] CMD_LD_R0   = 4'd9;
    localparam logic [3:0] CMD_LD_R1   = 4'd10;
    localparam logic [3:0] CMD_LD_RS   = 4'd12;

    localparam logic [3:0] FLG_ERR  = 4'd10;
    localparam logic [3:0] FLG_ZERO = 4'd2;
    localparam logic [3:0] FLG_OVF  = 4'd8;
    localparam logic [3:0] FLG_NONE = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT
    } state_e;

    typedef enum logic [1:0] {
        VIEW_RES,
        VIEW_R0,
        VIEW_R1,
        VIEW_RS
    } view_e;

    // Error dominates zero, zero dominates overflow.
    function automatic logic [3:0] flag_enc(
        input logic err,
        input logic zero,
        input logic ovf
    );
        logic [3:0] f;
        f = FLG_NONE;
        if (err) begin
            f = FLG_ERR;
        end else if (zero) begin
            f = FLG_ZERO;
        end else if (ovf) begin
            f = FLG_OVF;
        end
        return f;
    endfunction

endpackage

// File: rtl/calc_debounce.sv
// Button-code synchroniser and debouncer.
// Ports: clk_i, rst_ni, bt_i (raw async code) -> code_o (stable code).
module calc_debounce
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [CODE_W-1:0] bt_i,
    output logic [CODE_W-1:0] code_o
);

    localparam int CW = $clog2(DB_CYCLES);

    logic [CODE_W-1:0] sync1_q, sync2_q;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] stable_q, stable_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // cnt_q holds how many consecutive equal samples of cand_q have
    // been seen; the next equal sample after DB_CYCLES-1 accepts it.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CW'(1);
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= bt_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign code_o = stable_q;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator control core: debounced command decode, operand/opcode
// registers, execute sequencing with ALU wait, result/flag capture and
// display mux. Optional macro CALC_ACC_EN: result also written to r0.
// Ports: clk, rst_n, switch, bt, alu_result, alu_err/zero/ovf in;
// r0_o, r1_o, rs_o, disp_val, disp_flag, busy out.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int W         = 12,
    parameter int DB_CYCLES = 16,
    parameter int ALU_LAT   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] switch,
    input  logic [3:0]   bt,
    input  logic [W-1:0] alu_result,
    input  logic         alu_err,
    input  logic         alu_zero,
    input  logic         alu_ovf,
    output logic [W-1:0] r0_o,
    output logic [W-1:0] r1_o,
    output logic [3:0]   rs_o,
    output logic [W-1:0] disp_val,
    output logic [3:0]   disp_flag,
    output logic         busy
);

    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [3:0] code;

    state_e        state_q, state_d;
    view_e         view_q, view_d;
    logic [3:0]    acc_q, acc_d;
    logic [LW-1:0] wcnt_q, wcnt_d;
    logic          drop_q, drop_d;
    logic [W-1:0]  r0_q, r0_d;
    logic [W-1:0]  r1_q, r1_d;
    logic [3:0]    rs_q, rs_d;
    logic [W-1:0]  res_q, res_d;
    logic [3:0]    flag_q, flag_d;
    logic          commit;
    logic          capture;

    calc_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_db (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bt_i  (bt),
        .code_o(code)
    );

    always_comb begin
        state_d = state_q;
        view_d  = view_q;
        acc_d   = acc_q;
        wcnt_d  = wcnt_q;
        drop_d  = drop_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        rs_d    = rs_q;
        res_d   = res_q;
        flag_d  = flag_q;
        commit  = 1'b0;
        capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A press that began during WAIT is swallowed
                // until the code returns to zero.
                if (drop_q) begin
                    if (code == 4'd0) begin
                        drop_d = 1'b0;
                    end
                end else if (code != 4'd0) begin
                    state_d = ARMED;
                    acc_d   = code;
                end
            end
            ARMED: begin
                if (code != 4'd0) begin
                    acc_d = acc_q | code;
                end else begin
                    commit  = 1'b1;
                    acc_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (code != 4'd0) begin
                    drop_d = 1'b1;
                end
                if (wcnt_q == LW'(ALU_LAT - 1)) begin
                    capture = 1'b1;
                    wcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + LW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            case (acc_q)
                CMD_VIEW_R0: view_d = VIEW_R0;
                CMD_VIEW_R1: view_d = VIEW_R1;
                CMD_VIEW_RS: view_d = VIEW_RS;
                CMD_EXEC: begin
                    view_d  = VIEW_RES;
                    wcnt_d  = '0;
                    state_d = WAIT;
                end
                CMD_LD_R0: r0_d = switch;
                CMD_LD_R1: r1_d = switch;
                CMD_LD_RS: rs_d = switch[3:0];
                default: ;
            endcase
        end

        if (capture) begin
            res_d  = alu_result;
            flag_d = flag_enc(alu_err, alu_zero, alu_ovf);
`ifdef CALC_ACC_EN
            if (!alu_err) begin
                r0_d = alu_result;
            end
`else
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            view_q  <= VIEW_RES;
            acc_q   <= 4'd0;
            wcnt_q  <= '0;
            drop_q  <= 1'b0;
            r0_q    <= '0;
            r1_q    <= '0;
            rs_q    <= 4'd0;
            res_q   <= '0;
            flag_q  <= FLG_NONE;
        end else begin
            state_q <= state_d;
            view_q  <= view_d;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            drop_q  <= drop_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            rs_q    <= rs_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        disp_val = res_q;
        case (view_q)
            VIEW_R0: disp_val = r0_q;
            VIEW_R1: disp_val = r1_q;
            VIEW_RS: disp_val = W'(rs_q);
            default: disp_val = res_q;
        endcase
    end

    assign disp_flag = (view_q == VIEW_RES) ? flag_q : FLG_NONE;
    assign r0_o      = r0_q;
    assign r1_o      = r1_q;
    assign rs_o      = rs_q;
    assign busy      = (state_q == WAIT);

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: table of command vectors plus
// hand-written load-timing, glitch, execute, drop and reset sequences.
`timescale 1ns/1ps
module tb_calc_ctrl;

`ifdef CALC_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] sw0, sw1;
    logic [3:0]  bt0, bt1;
    logic [11:0] alu0, alu1;
    logic        err_f, zero_f, ovf_f;
    logic        nf;
    logic [11:0] r0a, r1a, dva;
    logic [3:0]  rsa, dfa;
    logic        busya;
    logic [11:0] r0b, r1b, dvb;
    logic [3:0]  rsb, dfb;
    logic        busyb;
    logic [11:0] p1, p2;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_r0;

    always #5 clk = ~clk;

    // Reference ALU: add with two-cycle latency.
    always @(posedge clk) begin
        p1 <= r0a + r1a;
        p2 <= p1;
    end
    assign alu0 = p2;
    assign alu1 = 12'd201;
    assign nf   = 1'b0;

    calc_ctrl #(.W(12), .DB_CYCLES(4), .ALU_LAT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .switch(sw0), .bt(bt0),
        .alu_result(alu0), .alu_err(err_f), .alu_zero(zero_f),
        .alu_ovf(ovf_f), .r0_o(r0a), .r1_o(r1a), .rs_o(rsa),
        .disp_val(dva), .disp_flag(dfa), .busy(busya)
    );

    calc_ctrl #(.W(12), .DB_CYCLES(4), .ALU_LAT(12)) u1 (
        .clk(clk), .rst_n(rst_n), .switch(sw1), .bt(bt1),
        .alu_result(alu1), .alu_err(nf), .alu_zero(nf),
        .alu_ovf(nf), .r0_o(r0b), .r1_o(r1b), .rs_o(rsb),
        .disp_val(dvb), .disp_flag(dfb), .busy(busyb)
    );

    typedef struct {
        logic [3:0]  bt;
        logic [11:0] sw;
        logic [11:0] r0;
        logic [11:0] r1;
        logic [3:0]  rs;
        logic [11:0] dv;
        logic [3:0]  df;
    } vec_t;

    vec_t tbl[8];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic press0(input logic [3:0] c, input int hold);
        bt0 = c;
        tick(hold);
        bt0 = 4'd0;
    endtask

    task automatic exec_chk(input string nm, input logic e, input logic z,
                            input logic o, input int exp_df);
        int exp_res;
        err_f   = e;
        zero_f  = z;
        ovf_f   = o;
        exp_res = (exp_r0 + 40) % 4096;
        press0(4'd8, 8);
        tick(6);
        chk({nm, " busy@6"}, busya, 0);
        tick(1);
        chk({nm, " busy@7"}, busya, 1);
        tick(1);
        chk({nm, " busy@8"}, busya, 1);
        tick(1);
        chk({nm, " busy@9"}, busya, 0);
        if (ACC && !e) exp_r0 = exp_res;
        chk({nm, " disp_val"}, dva, exp_res);
        chk({nm, " disp_flag"}, dfa, exp_df);
        chk({nm, " r0"}, r0a, exp_r0);
        err_f  = 1'b0;
        zero_f = 1'b0;
        ovf_f  = 1'b0;
        tick(3);
    endtask

    initial begin
        int seen;
        tbl[0] = '{4'd10, 12'd40,    12'd201, 12'd40, 4'd0, 12'd0,   4'd0};
        tbl[1] = '{4'd2,  12'd40,    12'd201, 12'd40, 4'd0, 12'd40,  4'd0};
        tbl[2] = '{4'd1,  12'd40,    12'd201, 12'd40, 4'd0, 12'd201, 4'd0};
        tbl[3] = '{4'd12, 12'h5A3,   12'd201, 12'd40, 4'd3, 12'd201, 4'd0};
        tbl[4] = '{4'd4,  12'h5A3,   12'd201, 12'd40, 4'd3, 12'd3,   4'd0};
        tbl[5] = '{4'd6,  12'd7,     12'd201, 12'd40, 4'd3, 12'd3,   4'd0};
        tbl[6] = '{4'd12, 12'd0,     12'd201, 12'd40, 4'd0, 12'd0,   4'd0};
        tbl[7] = '{4'd2,  12'd0,     12'd201, 12'd40, 4'd0, 12'd40,  4'd0};

        rst_n  = 1'b0;
        sw0    = '0;
        sw1    = '0;
        bt0    = '0;
        bt1    = '0;
        err_f  = 1'b0;
        zero_f = 1'b0;
        ovf_f  = 1'b0;
        tick(2);
        chk("rst r0", r0a, 0);
        chk("rst r1", r1a, 0);
        chk("rst rs", rsa, 0);
        chk("rst disp_val", dva, 0);
        chk("rst disp_flag", dfa, 0);
        chk("rst busy", busya, 0);
        rst_n = 1'b1;
        tick(2);

        // Drop: a whole press inside a long WAIT must not load r0.
        sw1 = 12'd201;
        bt1 = 4'd9;
        tick(8);
        bt1 = 4'd0;
        tick(9);
        chk("u1 load r0", r0b, 201);
        sw1 = 12'd99;
        bt1 = 4'd8;
        tick(8);
        bt1 = 4'd0;
        tick(7);
        chk("u1 busy start", busyb, 1);
        bt1 = 4'd9;
        tick(5);
        bt1 = 4'd0;
        tick(5);
        chk("u1 busy mid", busyb, 1);
        tick(20);
        chk("u1 busy end", busyb, 0);
        chk("u1 drop r0", r0b, 201);
        chk("u1 res", dvb, 201);

        // Load r0 via 1 then 9 in one press; exact release latency.
        sw0 = 12'd201;
        bt0 = 4'd1;
        tick(8);
        press0(4'd9, 10);
        tick(6);
        chk("load r0 @6", r0a, 0);
        tick(1);
        chk("load r0 @7", r0a, 201);
        chk("load view", dva, 0);
        tick(3);
        exp_r0 = 201;

        for (int i = 0; i < 8; i++) begin
            sw0 = tbl[i].sw;
            press0(tbl[i].bt, 8);
            tick(9);
            chk($sformatf("vec%0d r0", i), r0a, tbl[i].r0);
            chk($sformatf("vec%0d r1", i), r1a, tbl[i].r1);
            chk($sformatf("vec%0d rs", i), rsa, tbl[i].rs);
            chk($sformatf("vec%0d dv", i), dva, tbl[i].dv);
            chk($sformatf("vec%0d df", i), dfa, tbl[i].df);
        end

        // Short glitch never becomes a command.
        press0(4'd8, 3);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (busya) seen = 1;
        end
        chk("glitch busy", seen, 0);
        chk("glitch view", dva, 40);

        exec_chk("ex plain", 1'b0, 1'b0, 1'b0, 0);
        exec_chk("ex zero", 1'b0, 1'b1, 1'b0, 2);
        exec_chk("ex errzero", 1'b1, 1'b1, 1'b0, 10);
        exec_chk("ex ovf", 1'b0, 1'b0, 1'b1, 8);

        press0(4'd1, 8);
        tick(9);
        chk("view r0 dv", dva, exp_r0);
        chk("view r0 df", dfa, 0);

        // Reset in the middle of WAIT.
        press0(4'd8, 8);
        tick(7);
        chk("pre-rst busy", busya, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst r0", r0a, 0);
        chk("midrst r1", r1a, 0);
        chk("midrst rs", rsa, 0);
        chk("midrst dv", dva, 0);
        chk("midrst df", dfa, 0);
        chk("midrst busy", busya, 0);
        #2;
        rst_n = 1'b1;
        tick(10);
        chk("postrst busy", busya, 0);
        chk("postrst dv", dva, 0);
        sw0 = 12'd77;
        press0(4'd9, 8);
        tick(9);
        chk("postrst r0", r0a, 77);
        chk("postrst view", dva, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
